// File: rtl/seven_seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with a blank guard cycle between digits
// and frame-synchronous double buffering of the displayed data.
module seven_seg_scan_driver #(
    parameter int CLK_DIV = 100000
) (
    input  logic        in_clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic [3:0]  blank,
    output logic [7:0]  Seven_Seg,
    output logic [3:0]  digit,
    output logic        frame_done
);

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc_reg;
    logic [1:0]    idx_reg;
    logic          guard_reg;
    logic          pending_reg;
    logic [15:0]   shadow_value_reg, disp_value_reg, disp_value_next;
    logic [3:0]    shadow_dp_reg, disp_dp_reg, disp_dp_next;
    logic [3:0]    shadow_blank_reg, disp_blank_reg, disp_blank_next;
    logic [7:0]    seg_reg;

    logic          tick;
    logic          frame_end;
    logic [1:0]    idx_next;
    logic [7:0]    seg_pat [4];
    logic [3:0]    digit_sel [4];

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign tick      = (presc_reg == PRESC_LAST);
    assign frame_end = tick && (idx_reg == 2'd3);
    assign idx_next  = idx_reg + 2'd1;

    // Display data only ever changes on the frame-end tick, so a frame is never torn.
    always_comb begin
        disp_value_next = disp_value_reg;
        disp_dp_next    = disp_dp_reg;
        disp_blank_next = disp_blank_reg;
        if (frame_end) begin
            if (load) begin
                disp_value_next = value;
                disp_dp_next    = dp;
                disp_blank_next = blank;
            end else if (pending_reg) begin
                disp_value_next = shadow_value_reg;
                disp_dp_next    = shadow_dp_reg;
                disp_blank_next = shadow_blank_reg;
            end
        end
    end

    // Segment patterns are built from the data that will be live after this edge,
    // so the first digit of a new frame already shows the new data.
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        assign seg_pat[gi]   = disp_blank_next[gi] ? 8'hFF
                             : {~disp_dp_next[gi], hex_to_seg(disp_value_next[4*gi +: 4])};
        assign digit_sel[gi] = ~(4'b0001 << gi);
    end

    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            presc_reg        <= '0;
            idx_reg          <= '0;
            guard_reg        <= 1'b0;
            pending_reg      <= 1'b0;
            shadow_value_reg <= '0;
            shadow_dp_reg    <= '0;
            shadow_blank_reg <= '0;
            disp_value_reg   <= '0;
            disp_dp_reg      <= '0;
            disp_blank_reg   <= '0;
            seg_reg          <= 8'hC0;
        end else begin
            presc_reg      <= tick ? '0 : presc_reg + 1'b1;
            guard_reg      <= tick;
            disp_value_reg <= disp_value_next;
            disp_dp_reg    <= disp_dp_next;
            disp_blank_reg <= disp_blank_next;
            if (tick) begin
                idx_reg <= idx_next;
                // Segments switch on the edge that starts the all-dark guard cycle.
                seg_reg <= seg_pat[idx_next];
            end
            if (load) begin
                shadow_value_reg <= value;
                shadow_dp_reg    <= dp;
                shadow_blank_reg <= blank;
                pending_reg      <= !frame_end;
            end else if (frame_end) begin
                pending_reg <= 1'b0;
            end
        end
    end

    assign Seven_Seg  = seg_reg;
    assign digit      = guard_reg ? 4'b1111 : digit_sel[idx_reg];
    assign frame_done = frame_end;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Randomised scoreboard bench for seven_seg_scan_driver: a cycle-numbered frame model
// predicts digit/segment/frame_done every cycle; a monitor compares on the falling edge.
module tb_seven_seg_scan_driver;

    localparam int CLK_DIV = 4;
    localparam int FRAME   = 4 * CLK_DIV;

    logic        in_clk = 1'b0;
    logic        rst    = 1'b0;
    logic        load   = 1'b0;
    logic [15:0] value  = '0;
    logic [3:0]  dp     = '0;
    logic [3:0]  blank  = '0;
    logic [7:0]  Seven_Seg;
    logic [3:0]  digit;
    logic        frame_done;

    seven_seg_scan_driver #(.CLK_DIV(CLK_DIV)) dut (
        .in_clk     (in_clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .dp         (dp),
        .blank      (blank),
        .Seven_Seg  (Seven_Seg),
        .digit      (digit),
        .frame_done (frame_done)
    );

    always #5 in_clk = ~in_clk;

    typedef struct packed {
        logic [3:0] dig;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0]  seg_tbl [16];
    logic [15:0] cur_v, sh_v;
    logic [3:0]  cur_dp, cur_bl, sh_dp, sh_bl;
    bit          pend;
    int          t;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] enc(input logic [15:0] v, input logic [3:0] d,
                                       input logic [3:0] b, input int k);
        logic [7:0] s;
        logic [3:0] h;
        if (b[k]) return 8'hFF;
        h = v[4*k +: 4];
        s = seg_tbl[h];
        if (d[k]) s[7] = 1'b0;
        return s;
    endfunction

    // Model cycle t = interval after the t-th rising edge since reset release.
    task automatic run_cycle(input bit ld, input logic [15:0] v,
                             input logic [3:0] d, input logic [3:0] b);
        exp_t e;
        int slot, pos;
        slot  = (t / CLK_DIV) % 4;
        pos   = t % CLK_DIV;
        e.dig = (pos == 0 && t >= CLK_DIV) ? 4'b1111 : ~(4'b0001 << slot);
        e.seg = enc(cur_v, cur_dp, cur_bl, slot);
        e.fd  = (t % FRAME == FRAME - 1);
        q.push_back(e);
        load = ld; value = v; dp = d; blank = b;
        if (ld) $display("load t=%0d value=%h dp=%b blank=%b", t, v, d, b);
        if (t % FRAME == FRAME - 1) begin
            if (ld) begin
                cur_v = v; cur_dp = d; cur_bl = b;
            end else if (pend) begin
                cur_v = sh_v; cur_dp = sh_dp; cur_bl = sh_bl;
            end
            pend = 0;
        end else if (ld) begin
            sh_v = v; sh_dp = d; sh_bl = b; pend = 1;
        end
        @(posedge in_clk);
        #1;
        t++;
    endtask

    task automatic model_reset();
        t = 0; pend = 0;
        cur_v = '0; cur_dp = '0; cur_bl = '0;
        sh_v = '0; sh_dp = '0; sh_bl = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge in_clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected outputs never observed", q.size());
            q.delete();
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge in_clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("digit", {12'h0, digit}, {12'h0, e.dig});
                chk("seven_seg", {8'h0, Seven_Seg}, {8'h0, e.seg});
                chk("frame_done", {15'h0, frame_done}, {15'h0, e.fd});
            end
        end
    end

    initial begin : driver
        logic [15:0] v;
        bit ld;
        seg_tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        model_reset();

        // Outputs held at their reset values while the clock runs.
        repeat (3) begin
            @(negedge in_clk);
            chk("reset_digit", {12'h0, digit}, 16'h000E);
            chk("reset_seg", {8'h0, Seven_Seg}, 16'h00C0);
            chk("reset_fd", {15'h0, frame_done}, 16'h0000);
        end
        @(posedge in_clk);
        #1 rst = 1'b1;

        // Phase 1: directed loads early (incl. frame-end coincidence), then random traffic.
        while (t < 25 * FRAME + 6) begin
            case (t)
                21:  run_cycle(1, 16'h3A7F, 4'b0100, 4'b0000);
                40:  run_cycle(1, 16'h1234, 4'b0000, 4'b1001);
                52:  run_cycle(1, 16'h1111, 4'b0000, 4'b0000);
                58:  run_cycle(1, 16'h2222, 4'b0000, 4'b0000);
                79:  run_cycle(1, 16'hBEEF, 4'b1010, 4'b0000);
                402: run_cycle(1, 16'h8888, 4'b1111, 4'b0000);
                default: begin
                    ld = (t >= 96 && t < 400 && $urandom_range(0, 9) == 0);
                    v  = 16'($urandom);
                    run_cycle(ld, v, 4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
                end
            endcase
        end
        load = 1'b0;
        drain();

        // Asynchronous reset mid-slot with a load still pending.
        @(posedge in_clk);
        #3 rst = 1'b0;
        #1;
        chk("async_rst_digit", {12'h0, digit}, 16'h000E);
        chk("async_rst_seg", {8'h0, Seven_Seg}, 16'h00C0);
        chk("async_rst_fd", {15'h0, frame_done}, 16'h0000);
        repeat (3) begin
            @(negedge in_clk);
            chk("hold_rst_digit", {12'h0, digit}, 16'h000E);
            chk("hold_rst_seg", {8'h0, Seven_Seg}, 16'h00C0);
        end
        model_reset();
        @(posedge in_clk);
        #1 rst = 1'b1;

        // Phase 2: scanning resumes from slot 0 with cleared data; pending data must not appear.
        while (t < 12 * FRAME) begin
            ld = (t >= 2 * FRAME && t < 11 * FRAME && $urandom_range(0, 7) == 0);
            v  = 16'($urandom);
            run_cycle(ld, v, 4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
        end
        load = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
